// File: rtl/prio_enc_arb.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// prio_enc_arb : registered priority encoder / arbiter (fixed or round-robin)
//                with valid/ready result hold and an empty-sample pulse.
// Revision     : 1.0
//------------------------------------------------------------------------------
module prio_enc_arb #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDXW-1:0]  out_idx,
  output logic [WIDTH-1:0] out_onehot,
  output logic             none
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_ptr;
  logic [IDXW-1:0]  w_ptr_inc;
  logic [IDXW-1:0]  w_ptr_eff;
  logic [IDXW-1:0]  w_win;
  logic [WIDTH-1:0] w_onehot;
  logic             w_any;
  logic             w_accept;

  assign w_any     = |req;
  assign w_accept  = out_valid & out_ready;
  assign w_ptr_inc = (out_idx == IDXW'(WIDTH - 1)) ? '0 : out_idx + IDXW'(1);
  // A back-to-back grant must already see the pointer advanced past the result being accepted
  assign w_ptr_eff = ((MODE != 0) && w_accept) ? w_ptr_inc : r_ptr;
  assign w_onehot  = WIDTH'(1) << w_win;

  always_comb begin
    w_win = '0;
    if (MODE == 0) begin
      for (int i = 0; i < WIDTH; i++)
        if (req[i]) w_win = IDXW'(i);
    end else begin
      // First pass leaves the lowest set index (wrap fallback); second overrides with lowest >= ptr
      for (int i = WIDTH - 1; i >= 0; i--)
        if (req[i]) w_win = IDXW'(i);
      for (int i = WIDTH - 1; i >= 0; i--)
        if (req[i] && (IDXW'(i) >= w_ptr_eff)) w_win = IDXW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      none       <= 1'b0;
    end else begin
      none <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            if (w_any) begin
              out_idx    <= w_win;
              out_onehot <= w_onehot;
              out_valid  <= 1'b1;
              r_state    <= HOLD;
            end else begin
              none <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (MODE != 0) r_ptr <= w_ptr_inc;
            if (en && w_any) begin
              out_idx    <= w_win;
              out_onehot <= w_onehot;
            end else begin
              out_valid <= 1'b0;
              r_state   <= IDLE;
              none      <= en & ~w_any;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_arb.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_prio_enc_arb : scoreboard bench for a fixed-priority (W=8) and a
//                   round-robin (W=4) instance of prio_enc_arb.
// Revision        : 1.0
//------------------------------------------------------------------------------
module tb_prio_enc_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en0, rdy0, en1, rdy1;
  logic [7:0] req0;
  logic [3:0] req1;
  logic       v0, none0, v1, none1;
  logic [2:0] idx0;
  logic [7:0] oh0;
  logic [1:0] idx1;
  logic [3:0] oh1;

  prio_enc_arb #(.WIDTH(8), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .en(en0), .req(req0), .out_ready(rdy0),
    .out_valid(v0), .out_idx(idx0), .out_onehot(oh0), .none(none0)
  );

  prio_enc_arb #(.WIDTH(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .en(en1), .req(req1), .out_ready(rdy1),
    .out_valid(v1), .out_idx(idx1), .out_onehot(oh1), .none(none1)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int q0[$];
  int q1[$];

  // Reference state: current (m*) and after the coming edge (n*)
  bit mv[2], mn[2], nv[2], nn[2];
  int mi[2], mp[2], ni[2], np[2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Fixed: highest set bit via log2. Round-robin: first set bit scanning upward from ptr, cyclically.
  function automatic int winner(int k, int r, int p);
    if (k == 0) return $clog2(r + 1) - 1;
    for (int s = 0; s < 4; s++)
      if (((r >> ((p + s) % 4)) & 1) != 0) return (p + s) % 4;
    return -1;
  endfunction

  task automatic model_next();
    for (int k = 0; k < 2; k++) begin
      bit e, rd, sample;
      int r, p, w;
      w  = (k == 0) ? 8 : 4;
      e  = (k == 0) ? en0 : en1;
      rd = (k == 0) ? rdy0 : rdy1;
      r  = (k == 0) ? int'(req0) : int'(req1);
      sample = e && (!mv[k] || rd);
      p = mp[k];
      if (k == 1 && mv[k] && rd) p = (mi[k] + 1) % w;
      nv[k] = mv[k];
      ni[k] = mi[k];
      np[k] = p;
      nn[k] = sample && (r == 0);
      if (sample && r != 0) begin
        nv[k] = 1'b1;
        ni[k] = winner(k, r, p);
        if (k == 0) q0.push_back(ni[k]);
        else        q1.push_back(ni[k]);
      end else if (mv[k] && rd) begin
        nv[k] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; mn[k] = 1'b0; mi[k] = 0; mp[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mv[k] = nv[k]; mn[k] = nn[k]; mi[k] = ni[k]; mp[k] = np[k];
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_v0"}, v0, 0);     chk({tag, "_idx0"}, idx0, 0);
    chk({tag, "_oh0"}, oh0, 0);   chk({tag, "_none0"}, none0, 0);
    chk({tag, "_v1"}, v1, 0);     chk({tag, "_idx1"}, idx1, 0);
    chk({tag, "_oh1"}, oh1, 0);   chk({tag, "_none1"}, none1, 0);
  endtask

  // Monitor: compares every cycle; pops the scoreboard whenever a result is accepted
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("valid0", v0, mv[0]);
      chk("none0", none0, mn[0]);
      chk("held_idx0", idx0, mi[0]);
      if (v0) chk("onehot0", oh0, 64'd1 << mi[0]);
      if (v0 && rdy0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL acc0: accepted idx %0d, scoreboard empty at %0t", idx0, $time);
        end else chk("acc_idx0", idx0, q0.pop_front());
      end
      chk("valid1", v1, mv[1]);
      chk("none1", none1, mn[1]);
      chk("held_idx1", idx1, mi[1]);
      if (v1) chk("onehot1", oh1, 64'd1 << mi[1]);
      if (v1 && rdy1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL acc1: accepted idx %0d, scoreboard empty at %0t", idx1, $time);
        end else chk("acc_idx1", idx1, q1.pop_front());
      end
    end
  end

  int rr_seq[6]  = '{0, 1, 2, 3, 0, 1};
  int alt_seq[4] = '{2, 0, 2, 0};

  initial begin
    rst = 1'b1;
    en0 = 0; rdy0 = 0; req0 = '0;
    en1 = 0; rdy1 = 0; req1 = '0;
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("por");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_on = 1'b1;

    // Grant something, then assert reset mid-cycle: outputs clear without a clock edge
    en0 = 1; req0 = 8'h03; tick();
    chk("pre_rst_idx0", idx0, 1);
    en0 = 0; tick();
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1 rst = 1'b0;

    // First grant, fixed priority
    en0 = 1; req0 = 8'b0010_1100; rdy0 = 0; tick();
    chk("first_v0", v0, 1); chk("first_idx0", idx0, 5); chk("first_oh0", oh0, 8'b0010_0000);

    // Stall: result frozen while req changes
    req0 = 8'b1000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_idx0", idx0, 5);
    end
    rdy0 = 1; tick();
    chk("b2b_idx0", idx0, 7); chk("b2b_v0", v0, 1);

    // Accept into IDLE, then empty sample from IDLE, then disabled
    en0 = 0; tick();
    chk("drain_v0", v0, 0); chk("drain_none0", none0, 0);
    en0 = 1; req0 = 8'h00; tick();
    chk("empty_none0", none0, 1); chk("empty_v0", v0, 0);
    en0 = 0; req0 = 8'hFF; tick();
    chk("dis_none0", none0, 0); chk("dis_v0", v0, 0);
    tick();
    chk("dis2_v0", v0, 0);

    // Round-robin fairness with all requesters active, then alternating pair
    en1 = 1; req1 = 4'b1111; rdy1 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_all_idx1", idx1, rr_seq[i]);
    end
    req1 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_alt_idx1", idx1, alt_seq[i]);
    end

    // Wrap: grant 2 (ptr -> 3), then req 0011 wraps to 0, then 1
    en1 = 0; tick();
    en1 = 1; req1 = 4'b0100; rdy1 = 0; tick();
    chk("wrap_pre_idx1", idx1, 2);
    rdy1 = 1; req1 = 4'b0011; tick();
    chk("wrap_idx1", idx1, 0);
    tick();
    chk("wrap_next_idx1", idx1, 1);

    // Reset while holding: pointer returns to 0
    rdy1 = 0; tick();
    #3 rst = 1'b1;
    #1 chk("rst_hold_v1", v1, 0);
    model_reset();
    en1 = 0;
    @(posedge clk); #1 rst = 1'b0;
    en1 = 1; req1 = 4'b1010; rdy1 = 0; tick();
    chk("post_rst_idx1", idx1, 1); chk("post_rst_v1", v1, 1);

    // Randomised traffic on both instances
    for (int c = 0; c < 400; c++) begin
      en0  = ($urandom_range(3) != 0);
      req0 = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom);
      rdy0 = 1'($urandom_range(1));
      en1  = ($urandom_range(3) != 0);
      req1 = ($urandom_range(4) == 0) ? 4'h0 : 4'($urandom);
      rdy1 = 1'($urandom_range(1));
      tick();
    end

    en0 = 0; en1 = 0; rdy0 = 1; rdy1 = 1;
    tick();
    tick();
    chk("sb0_empty", q0.size(), 0);
    chk("sb1_empty", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
